// File: rtl/rom_byte_streamer.sv
// Streams a contiguous, wrapping byte range of a 1-cycle-latency RAM as valid/ready bytes with last and done.
// Latency: first byte 3 cycles after Start; at most 2 reads buffered or in flight, so stalls throttle reads immediately.
package AocPkg;
  localparam int ROM_DEPTH = 16;
  typedef logic [$clog2(ROM_DEPTH)-1:0] RomAddr_t;
endpackage

module rom_byte_streamer #(
  parameter int DEPTH  = AocPkg::ROM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Length,
  output logic [ADDR_W-1:0] RamReadAddr,
  output logic              RamReadEnable,
  input  logic [7:0]        RamReadData,
  output logic [7:0]        OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  delivered;
  logic              in_flight;
  logic [7:0]        fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;
  logic              pop;
  logic              issue;
  logic [1:0]        occ_after_pop;

  assign OutValid      = (fifo_count != 2'd0);
  assign OutData       = fifo_mem[rd_ptr];
  assign OutLast       = OutValid && (delivered == remaining - CNT_ONE);
  assign pop           = OutValid && OutReady;
  // Buffered plus in-flight reads, counting a byte leaving this cycle as already gone.
  assign occ_after_pop = fifo_count + 2'(in_flight) - 2'(pop);
  assign issue         = (state == STREAM) && (issued < remaining) && (occ_after_pop < 2'd2);
  assign RamReadEnable = issue;
  assign RamReadAddr   = addr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      issued      <= '0;
      delivered   <= '0;
      in_flight   <= 1'b0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done       <= 1'b0;
      in_flight  <= issue;
      fifo_count <= fifo_count + 2'(in_flight) - 2'(pop);
      if (in_flight) begin
        fifo_mem[wr_ptr] <= RamReadData;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        delivered <= delivered + CNT_ONE;
      end
      if (issue) begin
        issued <= issued + CNT_ONE;
        addr   <= (addr == LAST_ADDR) ? '0 : addr + ADDR_ONE;
      end

      case (state)
        IDLE: begin
          if (Start) begin
            addr      <= BaseAddr;
            remaining <= (Length > DEPTH_CNT) ? DEPTH_CNT : Length;
            issued    <= '0;
            delivered <= '0;
            if (Length == '0) begin
              state <= FINISH;
              Done  <= 1'b1;
            end else begin
              state <= STREAM;
              Busy  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (pop && OutLast) begin
            state <= FINISH;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Directed bench for rom_byte_streamer with a behavioural 1-cycle-latency byte RAM.
module tb_rom_byte_streamer;

  localparam int DEPTH = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] BaseAddr = '0;
  logic [4:0] Length = '0;
  logic [3:0] RamReadAddr;
  logic       RamReadEnable;
  logic [7:0] RamReadData;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady = 1'b1;
  logic       OutLast;
  logic       Busy;
  logic       Done;

  logic [7:0] ram [DEPTH];

  int total = 0;
  int bad = 0;

  int byte_q [$];
  int addr_q [$];
  int hs_c_q [$];
  int last_q [$];
  int done_cycle, busy_first, busy_last, bp_viol, stable_viol, valid_seen;

  rom_byte_streamer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .RamReadAddr(RamReadAddr), .RamReadEnable(RamReadEnable), .RamReadData(RamReadData),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .OutLast(OutLast),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (RamReadEnable) RamReadData <= ram[RamReadAddr];

  // Drives one stream from its Start cycle (c=0) and records what the DUT does each cycle.
  task automatic run_stream(input int base, input int len, input bit bp, input int extra_start,
                            input int reset_hs, input int budget);
    bit [5:0] pat = 6'b101001;
    int outstanding = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;
    bit hs;
    bit reset_fired = 0;
    byte_q.delete(); addr_q.delete(); hs_c_q.delete(); last_q.delete();
    done_cycle = -1; busy_first = -1; busy_last = -1;
    bp_viol = 0; stable_viol = 0; valid_seen = 0;
    for (int c = 0; c < budget && done_cycle < 0 && !reset_fired; c++) begin
      @(negedge Clk);
      Start    = (c == 0) || (c == extra_start);
      BaseAddr = (c == extra_start) ? 4'd8 : 4'(base);
      Length   = (c == extra_start) ? 5'd1 : 5'(len);
      OutReady = bp ? pat[c % 6] : 1'b1;
      #1;
      if (prev_stall && (!OutValid || OutData !== prev_data)) stable_viol++;
      hs = OutValid && OutReady;
      if (OutValid) valid_seen++;
      if (RamReadEnable) begin
        addr_q.push_back(int'(RamReadAddr));
        if (outstanding - int'(hs) >= 2) bp_viol++;
      end
      if (hs) begin
        byte_q.push_back(int'(OutData));
        hs_c_q.push_back(c);
        if (OutLast) last_q.push_back(byte_q.size() - 1);
        if (reset_hs > 0 && byte_q.size() == reset_hs) begin
          Reset = 1'b1;
          reset_fired = 1;
        end
      end
      outstanding += int'(RamReadEnable) - int'(hs);
      if (Busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
      if (Done) done_cycle = c;
    end
    Start = 1'b0;
    OutReady = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    #1;
    total++; if (RamReadAddr !== 4'd0)  begin bad++; $display("FAIL reset_addr got=%0h want=0", RamReadAddr); end
    total++; if (RamReadEnable !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", RamReadEnable); end
    total++; if (OutData !== 8'h00)     begin bad++; $display("FAIL reset_data got=%0h want=0", OutData); end
    total++; if (OutValid !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%0b want=0", OutValid); end
    total++; if (OutLast !== 1'b0)      begin bad++; $display("FAIL reset_last got=%0b want=0", OutLast); end
    total++; if (Busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%0b want=0", Busy); end
    total++; if (Done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%0b want=0", Done); end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'h41, 8'h42, 8'h43, 8'h0A};
    ram[0] = 8'h41; ram[1] = 8'h42; ram[2] = 8'h43; ram[3] = 8'h0A;
    run_stream(0, 4, 0, -1, 0, 40);
    total++; if (byte_q.size() != 4) begin bad++; $display("FAIL basic_count got=%0d want=4", byte_q.size()); end
    for (int k = 0; k < 4 && k < byte_q.size(); k++) begin
      total++; if (byte_q[k] != int'(exp_b[k])) begin bad++; $display("FAIL basic_byte%0d got=%0h want=%0h", k, byte_q[k], exp_b[k]); end
      total++; if (hs_c_q[k] != k + 3) begin bad++; $display("FAIL basic_cycle%0d got=%0d want=%0d", k, hs_c_q[k], k + 3); end
    end
    total++; if (last_q.size() != 1 || last_q[0] != 3) begin bad++; $display("FAIL basic_last got_n=%0d want index 3 only", last_q.size()); end
    total++; if (done_cycle != 7) begin bad++; $display("FAIL basic_done got=%0d want=7", done_cycle); end
    total++; if (busy_first != 1 || busy_last != 6) begin bad++; $display("FAIL basic_busy got=%0d..%0d want=1..6", busy_first, busy_last); end
    total++; if (addr_q.size() != 4 || addr_q[0] != 0 || addr_q[3] != 3) begin bad++; $display("FAIL basic_addrs got_n=%0d want 0..3", addr_q.size()); end
  endtask

  task automatic test_len0();
    run_stream(5, 0, 0, -1, 0, 10);
    total++; if (done_cycle != 1) begin bad++; $display("FAIL len0_done got=%0d want=1", done_cycle); end
    total++; if (addr_q.size() != 0) begin bad++; $display("FAIL len0_reads got=%0d want=0", addr_q.size()); end
    total++; if (valid_seen != 0) begin bad++; $display("FAIL len0_valid got=%0d want=0", valid_seen); end
    total++; if (busy_first != -1) begin bad++; $display("FAIL len0_busy got=%0d want=-1", busy_first); end
  endtask

  task automatic test_wrap();
    ram[14] = 8'h11; ram[15] = 8'h22; ram[0] = 8'h33;
    run_stream(14, 3, 0, -1, 0, 40);
    total++; if (addr_q.size() != 3 || addr_q[0] != 14 || addr_q[1] != 15 || addr_q[2] != 0)
      begin bad++; $display("FAIL wrap_addrs got_n=%0d want 14,15,0", addr_q.size()); end
    total++; if (byte_q.size() != 3 || byte_q[0] != 'h11 || byte_q[1] != 'h22 || byte_q[2] != 'h33)
      begin bad++; $display("FAIL wrap_bytes got_n=%0d want 11,22,33", byte_q.size()); end
    total++; if (last_q.size() != 1 || last_q[0] != 2) begin bad++; $display("FAIL wrap_last got_n=%0d want index 2", last_q.size()); end
    total++; if (done_cycle != 6) begin bad++; $display("FAIL wrap_done got=%0d want=6", done_cycle); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) ram[4 + i] = 8'(8'hA0 + i);
    run_stream(4, 6, 1, -1, 0, 100);
    total++; if (byte_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", byte_q.size()); end
    for (int k = 0; k < 6 && k < byte_q.size(); k++) begin
      total++; if (byte_q[k] != 'hA0 + k) begin bad++; $display("FAIL bp_byte%0d got=%0h want=%0h", k, byte_q[k], 'hA0 + k); end
    end
    total++; if (bp_viol != 0) begin bad++; $display("FAIL bp_overissue got=%0d want=0", bp_viol); end
    total++; if (stable_viol != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stable_viol); end
    total++; if (addr_q.size() != 6) begin bad++; $display("FAIL bp_reads got=%0d want=6", addr_q.size()); end
    total++; if (last_q.size() != 1 || last_q[0] != 5) begin bad++; $display("FAIL bp_last got_n=%0d want index 5", last_q.size()); end
  endtask

  task automatic test_overlong();
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i * 3 + 5);
    run_stream(3, DEPTH + 5, 0, -1, 0, 80);
    total++; if (byte_q.size() != DEPTH) begin bad++; $display("FAIL long_count got=%0d want=%0d", byte_q.size(), DEPTH); end
    for (int k = 0; k < byte_q.size(); k++) if (byte_q[k] != ((3 + k) % DEPTH) * 3 + 5) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL long_bytes got=%0d wrong want=0", errs); end
    total++; if (done_cycle != DEPTH + 3) begin bad++; $display("FAIL long_done got=%0d want=%0d", done_cycle, DEPTH + 3); end
    total++; if (last_q.size() != 1 || last_q[0] != DEPTH - 1) begin bad++; $display("FAIL long_last got_n=%0d want index %0d", last_q.size(), DEPTH - 1); end
  endtask

  task automatic test_start_ignored();
    int errs = 0;
    int busy_after = 0;
    run_stream(0, 5, 0, 3, 0, 40);
    for (int k = 0; k < byte_q.size(); k++) if (byte_q[k] != k * 3 + 5) errs++;
    total++; if (byte_q.size() != 5 || errs != 0) begin bad++; $display("FAIL ign_bytes got_n=%0d wrong=%0d want 5/0", byte_q.size(), errs); end
    total++; if (done_cycle != 8) begin bad++; $display("FAIL ign_done got=%0d want=8", done_cycle); end
    repeat (4) begin
      @(negedge Clk); #1;
      if (Busy || OutValid) busy_after++;
    end
    total++; if (busy_after != 0) begin bad++; $display("FAIL ign_restart got=%0d busy cycles want=0", busy_after); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    run_stream(0, 8, 0, -1, 3, 40);
    total++; if (byte_q.size() != 3) begin bad++; $display("FAIL rst_hs got=%0d want=3", byte_q.size()); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    total++; if ({RamReadAddr, RamReadEnable, OutData, OutValid, OutLast, Busy, Done} !== 18'd0)
      begin bad++; $display("FAIL rst_outputs got=%0h want=0", {RamReadAddr, RamReadEnable, OutData, OutValid, OutLast, Busy, Done}); end
    repeat (3) begin
      @(negedge Clk); #1;
      if (OutValid || Busy || RamReadEnable) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
    run_stream(0, 2, 0, -1, 0, 40);
    total++; if (byte_q.size() != 2 || byte_q[0] != 5 || byte_q[1] != 8)
      begin bad++; $display("FAIL rst_restart got_n=%0d want 05,08", byte_q.size()); end
    total++; if (done_cycle != 5) begin bad++; $display("FAIL rst_restart_done got=%0d want=5", done_cycle); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_backpressure();
    test_overlong();
    test_start_ignored();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
